sync_debounce_edge: RTL and testbench
=====================================

Name: sync_debounce_edge

Overview:
- Sits directly downstream of the multi-flop synchronizer. It consumes the already-synchronized level, which is in the clk domain.
- Rejects glitches and bounce shorter than a programmable number of cycles.
- Produces a clean debounced level plus single-cycle rise and fall pulses. These feed control FSMs and interrupt logic.
- Typical use: mechanical buttons, external status pins, slow handshake lines.

Parameters:
- CNT_W, 16, width of the stability counter.
- DEBOUNCE_CYCLES, 1000, number of consecutive identical samples required to commit a new level. Legal range is 1 to 2^CNT_W-1; out-of-range values are an elaboration error.
- INIT_LEVEL, 0, value of level_o and the stable state out of reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- sig_i  input  1  synchronized input level, already in the clk domain.
- en_i  input  1  debounce enable; 0 freezes the output level.
- level_o  output  1  debounced level, registered.
- rise_o  output  1  one-cycle pulse on a committed 0->1 transition, registered.
- fall_o  output  1  one-cycle pulse on a committed 1->0 transition, registered.
- busy_o  output  1  high while a candidate transition is being qualified. Decoded from the state register only.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state = STABLE_HI if INIT_LEVEL=1, else STABLE_LO.
  - level_o=INIT_LEVEL, rise_o=0, fall_o=0, cnt=0, busy_o=0.
  - Reset takes priority over all other inputs, including mid-qualification; any pending candidate is discarded with no pulse.
- States: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. busy_o=1 only in CHK_HI and CHK_LO.
- rise_o and fall_o default to 0 every cycle; each is asserted only on the commit edge. They are mutually exclusive and never high for two consecutive cycles.
- STABLE_LO:
  - sig_i=0: stay.
  - sig_i=1 and DEBOUNCE_CYCLES=1: commit immediately. Set level_o<=1, rise_o<=1, go to STABLE_HI.
  - sig_i=1 otherwise: cnt<=1, go to CHK_HI.
- CHK_HI:
  - sig_i=0: glitch rejected. cnt<=0, return to STABLE_LO, no pulse, level_o unchanged.
  - sig_i=1 and cnt==DEBOUNCE_CYCLES-1: commit. level_o<=1, rise_o<=1, cnt<=0, go to STABLE_HI.
  - sig_i=1 otherwise: cnt<=cnt+1.
- STABLE_HI and CHK_LO: mirror images of the above, with sig_i polarity inverted, level_o<=0 and fall_o<=1 on commit.
- Latency: level_o and the pulse become visible in the cycle after the edge that takes the DEBOUNCE_CYCLES-th consecutive differing sample. The first differing sample counts as sample 1.
- Counter: never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible. cnt is 0 in both STABLE states.
- en_i=0 at an edge:
  - Any CHK state returns to the STABLE state matching level_o.
  - cnt<=0, pulses 0, level_o held.
  - When en_i returns to 1, qualification restarts from sample 1.
- en_i=1 and sig_i toggling every cycle: never commits. busy_o alternates 1/0 (CHK on one cycle, STABLE on the next).

Optional Feature:
- Macro: SYNC_DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_cnt_o [7:0]. It increments by 1 on each rejected candidate, i.e. a CHK->STABLE return caused by sig_i reverting.
  - It saturates at 255.
  - Reset value is 0.
  - en_i-forced aborts do not count.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with INIT_LEVEL=0 (and a second build with INIT_LEVEL=1), sig_i=1 during reset -> level_o=INIT_LEVEL, rise_o=fall_o=busy_o=0 throughout reset; in the INIT_LEVEL=0 run, qualification starts at the first edge after rstn=1.
- DEBOUNCE_CYCLES=4, en_i=1, sig_i 0->1 held -> busy_o high for 3 cycles; level_o=1 and rise_o=1 in the cycle after the 4th high sample; rise_o=0 in the next cycle.
- DEBOUNCE_CYCLES=4, sig_i high for 3 samples then low -> level_o stays 0, no rise_o; with the macro defined, glitch_cnt_o=1. Then hold 1->0 the same way from STABLE_HI -> single fall_o pulse.
- DEBOUNCE_CYCLES=4, rstn=0 asserted after 2 high samples -> no pulse, level_o=0, cnt=0; after release with sig_i=1, 4 more samples are needed to commit.
- DEBOUNCE_CYCLES=4, en_i=0 after 3 high samples, en_i=1 two cycles later -> no commit while disabled; commit after 4 further high samples.
- DEBOUNCE_CYCLES=1, sig_i pattern 0,1,0,1 -> level_o follows sig_i delayed by 1 cycle, with alternating rise_o/fall_o pulses each cycle and busy_o always 0. Separately, with the macro, 300 rejected glitches -> glitch_cnt_o=255.

Source files
------------

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: debounces an already-synchronized level in the clk domain.
// A new level is committed only after DEBOUNCE_CYCLES consecutive samples that
// differ from the current level; a single-cycle rise_o/fall_o pulse marks the
// commit. en_i=0 abandons any candidate and freezes level_o.
// Optional feature macro: SYNC_DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt_o, a
// saturating count of candidates rejected because sig_i reverted.
module sync_debounce_edge #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sig_i,
  input  logic       en_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       busy_o
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt_o
`endif
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Reject unusable configurations at elaboration rather than misbehaving.
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
    $error("sync_debounce_edge: CNT_W=%0d out of range 1..32", CNT_W);
  end
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_cycles
    $error("sync_debounce_edge: DEBOUNCE_CYCLES=%0d out of range 1..2^CNT_W-1",
           DEBOUNCE_CYCLES);
  end

  // Count value at which the next agreeing sample is the DEBOUNCE_CYCLES-th.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               level_q, level_d;
  logic               rise_q,  rise_d;
  logic               fall_q,  fall_d;

  // Next-state, counter and commit-pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en_i) begin
      // Disable drops any candidate; the stable state always matches level_q.
      state_d = level_q ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STABLE_LO: begin
          cnt_d = '0;
          if (sig_i) begin
            if (IMMEDIATE) begin
              level_d = 1'b1;
              rise_d  = 1'b1;
              state_d = STABLE_HI;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = CHK_HI;
            end
          end
        end
        CHK_HI: begin
          if (!sig_i) begin
            cnt_d   = '0;
            state_d = STABLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
            state_d = STABLE_HI;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          cnt_d = '0;
          if (!sig_i) begin
            if (IMMEDIATE) begin
              level_d = 1'b0;
              fall_d  = 1'b1;
              state_d = STABLE_LO;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = CHK_LO;
            end
          end
        end
        CHK_LO: begin
          if (sig_i) begin
            cnt_d   = '0;
            state_d = STABLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
            state_d = STABLE_LO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = level_q ? STABLE_HI : STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  // Busy is a pure decode of the state register.
  assign busy_o  = (state_q == CHK_HI) || (state_q == CHK_LO);

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic       reject;
  logic [7:0] glitch_q, glitch_d;

  // A rejection is a CHK state seeing sig_i revert while enabled; disables do not count.
  always_comb begin
    reject   = en_i && (((state_q == CHK_HI) && !sig_i) ||
                        ((state_q == CHK_LO) &&  sig_i));
    glitch_d = glitch_q;
    if (reject && (glitch_q != '1)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // Saturating rejected-glitch counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Testbench for sync_debounce_edge. Three instances share one stimulus stream:
// DEBOUNCE_CYCLES=4/INIT_LEVEL=0, DEBOUNCE_CYCLES=1/INIT_LEVEL=0 and
// DEBOUNCE_CYCLES=4/INIT_LEVEL=1. A run-length reference model pushes the
// expected outputs of every cycle into a queue; each test pops and compares.
`timescale 1ns/1ps
module tb_sync_debounce_edge;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic sig  = 1'b0;
  logic en   = 1'b1;

  logic l4, r4, f4, b4;
  logic l1, r1, f1, b1;
  logic lh, rh, fh, bh;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] g4, g1, gh;
  localparam int VW = 36;
`else
  localparam int VW = 12;
`endif

  logic [VW-1:0] obs;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  assign obs = {l4, r4, f4, b4, l1, r1, f1, b1, lh, rh, fh, bh, g4, g1, gh};
`else
  assign obs = {l4, r4, f4, b4, l1, r1, f1, b1, lh, rh, fh, bh};
`endif

  always #5 clk = ~clk;

  sync_debounce_edge #(.CNT_W(16), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)) dut4 (
    .clk(clk), .rstn(rstn), .sig_i(sig), .en_i(en),
    .level_o(l4), .rise_o(r4), .fall_o(f4), .busy_o(b4)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(g4)
`endif
  );

  sync_debounce_edge #(.CNT_W(16), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)) dut1 (
    .clk(clk), .rstn(rstn), .sig_i(sig), .en_i(en),
    .level_o(l1), .rise_o(r1), .fall_o(f1), .busy_o(b1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(g1)
`endif
  );

  sync_debounce_edge #(.CNT_W(16), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b1)) duth (
    .clk(clk), .rstn(rstn), .sig_i(sig), .en_i(en),
    .level_o(lh), .rise_o(rh), .fall_o(fh), .busy_o(bh)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gh)
`endif
  );

  // Reference model: level plus length of the current run of differing samples.
  logic m_level  [3];
  int   m_run    [3];
  int   m_glitch [3];
  int   m_dc     [3] = '{4, 1, 4};
  logic m_init   [3] = '{1'b0, 1'b0, 1'b1};

  logic [VW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // Drive one cycle of stimulus {rstn, en, sig}, push the model's expectation,
  // then advance past the edge to the sampling point.
  task automatic drive(input logic [2:0] st);
    logic [3:0]    o  [3];
    logic [7:0]    gc [3];
    logic          rs, fl;
    logic [VW-1:0] v;
    rstn = st[2];
    en   = st[1];
    sig  = st[0];
    for (int i = 0; i < 3; i++) begin
      rs = 1'b0;
      fl = 1'b0;
      if (!st[2]) begin
        m_level[i]  = m_init[i];
        m_run[i]    = 0;
        m_glitch[i] = 0;
      end else if (!st[1]) begin
        m_run[i] = 0;
      end else if (st[0] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == m_dc[i]) begin
          m_level[i] = st[0];
          rs         = st[0];
          fl         = !st[0];
          m_run[i]   = 0;
        end
      end else begin
        if (m_run[i] > 0 && m_glitch[i] < 255) m_glitch[i] = m_glitch[i] + 1;
        m_run[i] = 0;
      end
      o[i]  = {m_level[i], rs, fl, (m_run[i] > 0)};
      gc[i] = 8'(m_glitch[i]);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    v = {o[0], o[1], o[2], gc[0], gc[1], gc[2]};
`else
    v = {o[0], o[1], o[2]};
`endif
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    repeat (3) stim.push_back(3'b011);
    repeat (6) stim.push_back(3'b111);
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_sb[%0d] got=%h want=%h", k, obs, e);
      end
      if (k < 3) begin
        checks++;
        if ({l4, lh, r4, f4, b4, rh, fh, bh} !== 8'b01000000) begin
          errors++;
          $display("FAIL reset_hold[%0d] got=%b want=01000000", k,
                   {l4, lh, r4, f4, b4, rh, fh, bh});
        end
      end
      if (k == 3) begin
        checks++;
        if (b4 !== 1'b1) begin
          errors++;
          $display("FAIL reset_first_sample got=%b want=1", b4);
        end
      end
    end
  endtask

  task automatic test_rise();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    int busy_n = 0, rise_n = 0, rise_at = -1;
    repeat (6) stim.push_back(3'b110);
    repeat (6) stim.push_back(3'b111);
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rise_sb[%0d] got=%h want=%h", k, obs, e);
      end
      if (k >= 6) begin
        busy_n += int'(b4);
        rise_n += int'(r4);
        if (r4 === 1'b1 && rise_at < 0) rise_at = k - 6;
      end
    end
    checks++;
    if (busy_n != 3 || rise_n != 1 || rise_at != 3) begin
      errors++;
      $display("FAIL rise_timing got busy=%0d rises=%0d at=%0d want busy=3 rises=1 at=3",
               busy_n, rise_n, rise_at);
    end
  endtask

  task automatic test_glitch();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    int rise_glitch = 0, fall_n = 0;
    repeat (6) stim.push_back(3'b110);
    repeat (3) stim.push_back(3'b111);
    repeat (3) stim.push_back(3'b110);
    repeat (5) stim.push_back(3'b111);
    repeat (6) stim.push_back(3'b110);
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL glitch_sb[%0d] got=%h want=%h", k, obs, e);
      end
      if (k >= 6 && k < 12) rise_glitch += int'(r4) + int'(l4);
      if (k >= 17) fall_n += int'(f4);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      if (k == 11) begin
        checks++;
        if (g4 !== 8'd1) begin
          errors++;
          $display("FAIL glitch_count got=%0d want=1", g4);
        end
      end
`endif
    end
    checks++;
    if (rise_glitch != 0 || fall_n != 1) begin
      errors++;
      $display("FAIL glitch_pulses got glitch_hits=%0d falls=%0d want 0 and 1",
               rise_glitch, fall_n);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    int rise_at = -1, pulses = 0;
    repeat (2) stim.push_back(3'b110);
    repeat (2) stim.push_back(3'b111);
    stim.push_back(3'b011);
    repeat (6) stim.push_back(3'b111);
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_sb[%0d] got=%h want=%h", k, obs, e);
      end
      if (k <= 4) pulses += int'(r4) + int'(l4) + int'(f4);
      if (k >= 5 && r4 === 1'b1 && rise_at < 0) rise_at = k - 5;
    end
    checks++;
    if (pulses != 0 || rise_at != 3) begin
      errors++;
      $display("FAIL reset_mid_timing got early=%0d rise_at=%0d want 0 and 3",
               pulses, rise_at);
    end
  endtask

  task automatic test_enable();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    int rise_at = -1, early = 0;
    repeat (6) stim.push_back(3'b110);
    repeat (3) stim.push_back(3'b111);
    repeat (2) stim.push_back(3'b101);
    repeat (6) stim.push_back(3'b111);
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL enable_sb[%0d] got=%h want=%h", k, obs, e);
      end
      if (k >= 6 && k < 11) early += int'(r4) + int'(l4);
      if (k >= 11 && r4 === 1'b1 && rise_at < 0) rise_at = k - 11;
    end
    checks++;
    if (early != 0 || rise_at != 3) begin
      errors++;
      $display("FAIL enable_timing got early=%0d rise_at=%0d want 0 and 3", early, rise_at);
    end
  endtask

  task automatic test_dc1_toggle();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    logic          prev;
    int bad = 0;
    repeat (6) stim.push_back(3'b110);
    for (int i = 0; i < 10; i++) stim.push_back({2'b11, 1'(i % 2)});
    prev = 1'b0;
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL dc1_sb[%0d] got=%h want=%h", k, obs, e);
      end
      if (k >= 6) begin
        if (l1 !== stim[k][0] || b1 !== 1'b0 || r1 !== (stim[k][0] & ~prev) ||
            f1 !== (~stim[k][0] & prev) || l4 !== 1'b0 || b4 !== stim[k][0])
          bad++;
        prev = stim[k][0];
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dc1_toggle got bad_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_glitch_sat();
    logic [2:0]    stim [$];
    logic [VW-1:0] e;
    repeat (6) stim.push_back(3'b110);
    for (int i = 0; i < 300; i++) begin
      stim.push_back(3'b111);
      stim.push_back(3'b110);
    end
    foreach (stim[k]) begin
      drive(stim[k]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL glitch_sat_sb[%0d] got=%h want=%h", k, obs, e);
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (g4 !== 8'd255) begin
      errors++;
      $display("FAIL glitch_sat got=%0d want=255", g4);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_level[i]  = m_init[i];
      m_run[i]    = 0;
      m_glitch[i] = 0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_rise();
    test_glitch();
    test_reset_mid();
    test_enable();
    test_dc1_toggle();
    test_glitch_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
